// File: rtl/clkmon_pkg.sv
// clkmon_pkg: shared state/fault-code types and counter width for clock_monitor.
// Contents: state_t (FSM states), fault_code_t (fault causes), CNT_W (measurement width).
package clkmon_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, LOCKED, FAULT} state_t;

    typedef enum logic [1:0] {FC_NONE, FC_SHORT, FC_LONG, FC_RSVD} fault_code_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer for an asynchronous input plus an any-edge pulse.
// Ports: clk (clock), rst (async active-high reset), din (async input),
//        any_edge (one-cycle pulse on each rising or falling edge of the synchronized input).
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic any_edge
);

    // sr[0], sr[1] form the synchronizer; sr[2] holds the previous synchronized value
    logic [2:0] sr;

    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], din};

    assign any_edge = sr[2] ^ sr[1];

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: half-period frequency checker for a slow divided clock, with lock and sticky fault reporting.
// Ports: clock1M (clock), reset (async active-high), enable (level), clk_in (async monitored clock),
//        clear_fault (pulse), half_period (last measurement, saturating), meas_valid (update pulse),
//        locked, fault (sticky), fault_code (00 none, 01 short, 10 long/stuck), min_half/max_half (statistics).
// Optional: define CLKMON_STATS_EN to build min_half/max_half tracking; otherwise both are tied to 0.
module clock_monitor
    import clkmon_pkg::*;
#(
    parameter int unsigned EXP_HALF = 50,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_in,
    input  logic             clear_fault,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] min_half,
    output logic [CNT_W-1:0] max_half
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LO = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] HI = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TO = CNT_W'(EXP_HALF + TOL + 1);
    localparam logic [GW-1:0] LOCK_G  = GW'(LOCK_CNT);
    localparam logic [GW-1:0] LOCK_M1 = GW'(LOCK_CNT - 1);

    if (EXP_HALF <= TOL) begin : g_bad_cfg
        $error("clock_monitor: EXP_HALF-TOL must be at least 1");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic             any_edge;

    sync_edge_detect u_sync (
        .clk      (clock1M),
        .rst      (reset),
        .din      (clk_in),
        .any_edge (any_edge)
    );

    // a measurement is only taken on edges seen while actively measuring
    logic meas, short_m, long_m, timeout;
    assign meas    = enable && any_edge && (state == MEASURE || state == LOCKED);
    assign short_m = meas && cnt < LO;
    assign long_m  = meas && cnt > HI;
    // an edge in the timeout cycle wins and is judged as a measurement instead
    assign timeout = enable && !any_edge && cnt >= TO && (state == MEASURE || state == LOCKED);

    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            good_cnt    <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            meas_valid <= meas;
            cnt        <= any_edge ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
            if (meas) half_period <= cnt;
            if (!enable && state != FAULT) begin
                state    <= IDLE;
                cnt      <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                        cnt   <= '0;
                    end
                    ACQUIRE: if (any_edge) state <= MEASURE;
                    MEASURE, LOCKED: begin
                        if (short_m || long_m || timeout) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= short_m ? FC_SHORT : FC_LONG;
                            locked     <= 1'b0;
                            good_cnt   <= '0;
                        end else if (meas) begin
                            if (good_cnt >= LOCK_M1) begin
                                good_cnt <= LOCK_G;
                                state    <= LOCKED;
                                locked   <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end
                    end
                    FAULT: if (clear_fault) begin
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        state      <= enable ? ACQUIRE : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CLKMON_STATS_EN
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset || (state == FAULT && clear_fault)) begin
            min_half <= '1;
            max_half <= '0;
        end else if (meas) begin
            if (cnt < min_half) min_half <= cnt;
            if (cnt > max_half) max_half <= cnt;
        end
    end
`else
    assign min_half = '0;
    assign max_half = '0;
`endif

endmodule
